// File: rtl/pipe_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline (pc, if2id, id2exe, exe2mem,
// mem2wb). Merges exception, data-memory wait, divide hold, load-use and
// instruction-fetch wait into per-register stall/flush controls, and
// sequences the fixed-latency iterative divider.
//
// Handshake with the divider: div_start_o is a single-cycle pulse issued in
// the cycle the DIV leaves IDLE. The result is valid DIV_CYCLES cycles later,
// which is the DIV_DONE cycle. div_abort_o is a single-cycle pulse issued
// only when an exception arrives while the divider is busy. Neither side
// applies back-pressure.
//
// div_busy_o covers the start cycle plus every DIV_BUSY cycle. DIV_BUSY lasts
// DIV_CYCLES-1 cycles, so the pipeline is held for exactly DIV_CYCLES cycles
// per divide.
module pipe_ctrl #(
  parameter int DIV_CYCLES = 32
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic       ex_rmem_i,
  input  logic       ex_wreg_i,
  input  logic [4:0] ex_wdst_i,
  input  logic       ex_div_i,
  input  logic       imem_stall_i,
  input  logic       dmem_req_i,
  input  logic       dmem_ack_i,
  input  logic       except_i,
  output logic       stall_pc_o,
  output logic       stall_if2id_o,
  output logic       stall_id2exe_o,
  output logic       stall_exe2mem_o,
  output logic       stall_mem2wb_o,
  output logic       flush_if2id_o,
  output logic       flush_id2exe_o,
  output logic       flush_exe2mem_o,
  output logic       flush_mem2wb_o,
  output logic       div_start_o,
  output logic       div_abort_o,
  output logic       div_busy_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } state_t;

  localparam logic [5:0] CNT_LOAD = 6'(DIV_CYCLES - 1);

  state_t     r_state;
  state_t     w_state_next;
  logic [5:0] r_cnt;
  logic [5:0] w_cnt_next;
  logic [5:0] w_cnt_dec;
  logic       w_dmem_wait;
  logic       w_load_use;
  logic       w_div_start;
  logic       w_div_hold;

  // Hazard conditions derived from the current state and inputs.
  always_comb begin
    w_dmem_wait = dmem_req_i & ~dmem_ack_i;
    w_load_use  = ex_rmem_i & ex_wreg_i & (ex_wdst_i != 5'd0) &
                  ((ex_wdst_i == id_rs_i) | (ex_wdst_i == id_rt_i));
    w_div_start = (r_state == IDLE) & ex_div_i & ~except_i & ~w_dmem_wait;
    w_div_hold  = (r_state == DIV_BUSY) | w_div_start;
    w_cnt_dec   = r_cnt - 6'd1;
  end

  // Next-state and divide counter; a committed exception always returns to IDLE.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_div_start) begin
          w_state_next = DIV_BUSY;
          w_cnt_next   = CNT_LOAD;
        end
      end
      DIV_BUSY: begin
        // Keeps counting through data-memory waits so the divide stays on schedule.
        w_cnt_next = w_cnt_dec;
        if (w_cnt_dec == 6'd0) begin
          w_state_next = DIV_DONE;
        end
      end
      DIV_DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
        w_cnt_next   = 6'd0;
      end
    endcase
    if (except_i) begin
      w_state_next = IDLE;
      w_cnt_next   = 6'd0;
    end
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_cnt   <= 6'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Priority-resolved stall/flush outputs; each rule stalls the registers
  // upstream of the hazard and bubbles the one just downstream.
  always_comb begin
    stall_pc_o      = 1'b0;
    stall_if2id_o   = 1'b0;
    stall_id2exe_o  = 1'b0;
    stall_exe2mem_o = 1'b0;
    stall_mem2wb_o  = 1'b0;
    flush_if2id_o   = 1'b0;
    flush_id2exe_o  = 1'b0;
    flush_exe2mem_o = 1'b0;
    flush_mem2wb_o  = 1'b0;
    div_start_o     = 1'b0;
    div_abort_o     = 1'b0;
    div_busy_o      = 1'b0;
    if (!rst_i) begin
      div_start_o = w_div_start;
      div_abort_o = except_i & (r_state == DIV_BUSY);
      div_busy_o  = w_div_hold;
      if (except_i) begin
        // PC loads the handler address, so nothing is held.
        flush_if2id_o   = 1'b1;
        flush_id2exe_o  = 1'b1;
        flush_exe2mem_o = 1'b1;
        flush_mem2wb_o  = 1'b1;
      end else if (w_dmem_wait) begin
        stall_pc_o      = 1'b1;
        stall_if2id_o   = 1'b1;
        stall_id2exe_o  = 1'b1;
        stall_exe2mem_o = 1'b1;
        flush_mem2wb_o  = 1'b1;
      end else if (w_div_hold) begin
        stall_pc_o      = 1'b1;
        stall_if2id_o   = 1'b1;
        stall_id2exe_o  = 1'b1;
        flush_exe2mem_o = 1'b1;
      end else if (w_load_use) begin
        stall_pc_o      = 1'b1;
        stall_if2id_o   = 1'b1;
        flush_id2exe_o  = 1'b1;
      end else if (imem_stall_i) begin
        stall_pc_o      = 1'b1;
        flush_if2id_o   = 1'b1;
      end
    end
  end

endmodule
